// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// program_loader : byte-stream boot loader, packs big-endian pairs into RAM
// Revision 1.0
// ============================================================================
module program_loader #(
  parameter int              ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] BASE_ADR = '0,
  parameter logic [15:0]     TIMEOUT  = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [15:0]       ram_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_N, S_GET_HI, S_GET_LO, S_WRITE, S_GET_CK, S_DONE, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        n_q, n_d;
  logic [7:0]        idx_q, idx_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       tmo_q, tmo_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              xfer;

  assign in_ready  = (state_q == S_GET_N)  || (state_q == S_GET_HI) ||
                     (state_q == S_GET_LO) || (state_q == S_GET_CK);
  assign xfer      = in_valid && in_ready;
  assign ram_we    = (state_q == S_WRITE);
  assign ram_adr   = adr_q;
  assign ram_wdata = wdata_q;
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERROR);
  assign cpu_hold  = (state_q != S_DONE);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    hi_d    = hi_q;
    tmo_d   = '0;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_GET_N;
          sum_d   = '0;
          idx_d   = '0;
        end
      end
      S_GET_N: begin
        if (xfer) begin
          n_d     = in_data;
          sum_d   = in_data;
          state_d = (in_data == 8'h00) ? S_ERROR : S_GET_HI;
        end
      end
      S_GET_HI: begin
        if (xfer) begin
          hi_d    = in_data;
          sum_d   = sum_q + in_data;
          state_d = S_GET_LO;
        end
      end
      S_GET_LO: begin
        // Address/data are registered here so they are valid throughout WRITE.
        if (xfer) begin
          sum_d   = sum_q + in_data;
          wdata_d = {hi_q, in_data};
          adr_d   = BASE_ADR + ADDR_W'(idx_q);
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (idx_q + 8'd1 == n_q) begin
          state_d = S_GET_CK;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_GET_HI;
        end
      end
      S_GET_CK: begin
        if (xfer) begin
          sum_d   = sum_q + in_data;
          state_d = (sum_d == 8'h00) ? S_DONE : S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Idle gap between bytes; a transfer in the same cycle wins.
    if (in_ready && !xfer) begin
      tmo_d = tmo_q + 16'd1;
      if (tmo_d == TIMEOUT) begin
        state_d = S_ERROR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      hi_q    <= '0;
      tmo_q   <= '0;
      adr_q   <= BASE_ADR;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      hi_q    <= hi_d;
      tmo_q   <= tmo_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// tb_program_loader : directed bench; dut0 default params, dut1 BASE_ADR=FF, TIMEOUT=16
// Revision 1.0
// ============================================================================
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;

  logic        rdy0, we0, hold0, done0, err0;
  logic [7:0]  adr0;
  logic [15:0] wd0;
  logic        rdy1, we1, hold1, done1, err1;
  logic [7:0]  adr1;
  logic [15:0] wd1;

  int checks = 0;
  int failures = 0;

  logic [23:0] log0 [0:63];
  logic [23:0] log1 [0:63];
  int wcnt0 = 0;
  int wcnt1 = 0;
  int b0, b1;

  always #5 clk = ~clk;

  program_loader dut0 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy0), .ram_we(we0), .ram_adr(adr0), .ram_wdata(wd0),
    .cpu_hold(hold0), .done(done0), .error(err0)
  );

  program_loader #(.ADDR_W(8), .BASE_ADR(8'hFF), .TIMEOUT(16'd16)) dut1 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .ram_we(we1), .ram_adr(adr1), .ram_wdata(wd1),
    .cpu_hold(hold1), .done(done1), .error(err1)
  );

  always @(negedge clk) begin
    if (we0 && wcnt0 < 64) begin log0[wcnt0] = {adr0, wd0}; wcnt0++; end
    if (we1 && wcnt1 < 64) begin log1[wcnt1] = {adr1, wd1}; wcnt1++; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!rdy0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("handshake_wait", 32'(guard), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state
    do_reset();
    chk("rst_hold",  {31'd0, hold0}, 32'd1);
    chk("rst_we",    {31'd0, we0},   32'd0);
    chk("rst_ready", {31'd0, rdy0},  32'd0);
    chk("rst_done",  {31'd0, done0}, 32'd0);
    chk("rst_err",   {31'd0, err0},  32'd0);
    chk("rst_adr0",  {24'd0, adr0},  32'h00);
    chk("rst_adr1",  {24'd0, adr1},  32'hFF);
    @(negedge clk); reset = 1'b1;

    // 2: good two-word frame; dut1 wraps FF -> 00
    b0 = wcnt0; b1 = wcnt1;
    pulse_start();
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h40);
    chk("t2_cnt0", 32'(wcnt0 - b0), 32'd2);
    chk("t2_w0a", {8'd0, log0[b0]},   32'h001234);
    chk("t2_w0b", {8'd0, log0[b0+1]}, 32'h01ABCD);
    chk("t2_w1a", {8'd0, log1[b1]},   32'hFF1234);
    chk("t2_w1b", {8'd0, log1[b1+1]}, 32'h00ABCD);
    chk("t2_done", {31'd0, done0}, 32'd1);
    chk("t2_hold", {31'd0, hold0}, 32'd0);
    chk("t2_err",  {31'd0, err0},  32'd0);
    chk("t2_rdy",  {31'd0, rdy0},  32'd0);
    chk("t2_adr_hold", {24'd0, adr0}, 32'h01);
    // in_valid while DONE is ignored
    @(negedge clk); in_valid = 1'b1; in_data = 8'h77;
    repeat (3) @(posedge clk);
    #1;
    chk("t2_idle_done", {31'd0, done0}, 32'd1);
    chk("t2_idle_we",   32'(wcnt0 - b0), 32'd2);
    in_valid = 1'b0;

    // 3: bad checksum
    b0 = wcnt0;
    pulse_start();
    chk("t3_hold_restart", {31'd0, hold0}, 32'd1);
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h41);
    chk("t3_cnt0", 32'(wcnt0 - b0), 32'd2);
    chk("t3_err",  {31'd0, err0},  32'd1);
    chk("t3_done", {31'd0, done0}, 32'd0);
    chk("t3_hold", {31'd0, hold0}, 32'd1);

    // 4: zero count, then recovery with a one-word frame
    b0 = wcnt0;
    pulse_start();
    chk("t4_err_cleared", {31'd0, err0}, 32'd0);
    send_byte(8'h00);
    chk("t4_err",  {31'd0, err0}, 32'd1);
    chk("t4_nowr", 32'(wcnt0 - b0), 32'd0);
    b1 = wcnt1;
    pulse_start();
    send_byte(8'h01); send_byte(8'h55); send_byte(8'hAA); send_byte(8'h00);
    chk("t4_done", {31'd0, done0}, 32'd1);
    chk("t4_err2", {31'd0, err0},  32'd0);
    chk("t4_w0",   {8'd0, log0[b0]}, 32'h0055AA);
    chk("t4_w1",   {8'd0, log1[b1]}, 32'hFF55AA);

    // 5: stall after HI byte; dut1 times out after 16 idle edges
    pulse_start();
    send_byte(8'h02); send_byte(8'h12);
    repeat (15) @(posedge clk);
    #1;
    chk("t5_pre_err", {31'd0, err1}, 32'd0);
    chk("t5_pre_rdy", {31'd0, rdy1}, 32'd1);
    @(posedge clk);
    #1;
    chk("t5_err1", {31'd0, err1}, 32'd1);
    chk("t5_rdy1", {31'd0, rdy1}, 32'd0);
    chk("t5_err0", {31'd0, err0}, 32'd0);

    // 6: reset mid-frame, then a fresh load
    do_reset();
    @(negedge clk); reset = 1'b1;
    pulse_start();
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    do_reset();
    chk("t6_rdy",   {31'd0, rdy0},  32'd0);
    chk("t6_we",    {31'd0, we0},   32'd0);
    chk("t6_adr0",  {24'd0, adr0},  32'h00);
    chk("t6_adr1",  {24'd0, adr1},  32'hFF);
    chk("t6_wd",    {16'd0, wd0},   32'h0000);
    chk("t6_hold",  {31'd0, hold0}, 32'd1);
    chk("t6_done",  {31'd0, done0}, 32'd0);
    chk("t6_err",   {31'd0, err0},  32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_idle_rdy", {31'd0, rdy0}, 32'd0);
    b0 = wcnt0;
    pulse_start();
    send_byte(8'h01); send_byte(8'h55); send_byte(8'hAA); send_byte(8'h00);
    chk("t6_done2", {31'd0, done0}, 32'd1);
    chk("t6_hold2", {31'd0, hold0}, 32'd0);
    chk("t6_w0",    {8'd0, log0[b0]}, 32'h0055AA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
